spacewar_ship_kinematics: RTL and testbench

//  Time-multiplexed motion engine for NUM_SHIPS spacewar ships on a toroidal playfield.

---
 rtl/spacewar_pkg.sv | 50 +++++
 rtl/spacewar_wrap_add.sv | 26 ++
 rtl/spacewar_ship_kinematics.sv | 189 ++++++++++++++++++
 tb/tb_spacewar_ship_kinematics.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spacewar_pkg.sv
// Shared types and helpers for the spacewar ship kinematics engine.
//  - heading_t : 3-bit heading, 0..7, 45 degrees per step, counter-clockwise.
//  - accel_t   : signed unit thrust vector (dx, dy), y grows downward.
//  - ROT_L / ROT_R / THRUST : bit positions inside a ship's 3-bit control field.
//  - accel()   : heading -> thrust vector lookup.
//  - sat_add() : add with symmetric saturation at +/-lim.
package spacewar_pkg;

  typedef logic [2:0] heading_t;

  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } accel_t;

  localparam int unsigned ROT_L  = 0;
  localparam int unsigned ROT_R  = 1;
  localparam int unsigned THRUST = 2;

  function automatic accel_t accel(input heading_t h);
    accel_t a;
    a.dx = 2'sd0;
    a.dy = 2'sd0;
    unique case (h)
      3'd0: begin a.dx = 2'sd1;  a.dy = 2'sd0;  end
      3'd1: begin a.dx = 2'sd1;  a.dy = -2'sd1; end
      3'd2: begin a.dx = 2'sd0;  a.dy = -2'sd1; end
      3'd3: begin a.dx = -2'sd1; a.dy = -2'sd1; end
      3'd4: begin a.dx = -2'sd1; a.dy = 2'sd0;  end
      3'd5: begin a.dx = -2'sd1; a.dy = 2'sd1;  end
      3'd6: begin a.dx = 2'sd0;  a.dy = 2'sd1;  end
      3'd7: begin a.dx = 2'sd1;  a.dy = 2'sd1;  end
      default: begin a.dx = 2'sd0; a.dy = 2'sd0; end
    endcase
    return a;
  endfunction

  // Symmetric clamp keeps the most negative two's-complement code unused.
  function automatic int sat_add(input int v, input int a, input int lim);
    int s;
    s = v + a;
    if (s > lim) begin
      s = lim;
    end else if (s < -lim) begin
      s = -lim;
    end
    return s;
  endfunction

endpackage

// File: rtl/spacewar_wrap_add.sv
// Combinational position update on a toroidal axis: sum = (pos + vel) mod FIELD.
//  pos : unsigned position, 0..FIELD-1
//  vel : signed velocity, |vel| < FIELD so a single correction is enough
//  sum : wrapped result, 0..FIELD-1
module spacewar_wrap_add #(
  parameter int POS_W = 10,
  parameter int VEL_W = 6,
  parameter int FIELD = 640
) (
  input  logic [POS_W-1:0]        pos,
  input  logic signed [VEL_W-1:0] vel,
  output logic [POS_W-1:0]        sum
);

  always_comb begin
    int s;
    s = int'(pos) + int'(vel);
    if (s < 0) begin
      s = s + FIELD;
    end else if (s >= FIELD) begin
      s = s - FIELD;
    end
    sum = POS_W'(s);
  end

endmodule

// File: rtl/spacewar_ship_kinematics.sv
// Time-multiplexed motion engine for NUM_SHIPS ships on a toroidal playfield.
// Each frame_tick starts one pass that updates ship 0..N-1, one ship per cycle,
// through a single shared heading/velocity/position datapath.
//  clk, rst     : clock, synchronous active-high reset
//  frame_tick   : one-cycle pulse starting a pass (ignored and flagged if a pass is active)
//  ctrl_in      : per ship {thrust, rot_r, rot_l}, ship i at [3i+2:3i]; snapshotted on start
//  rd_idx       : ship selected on the read port; out-of-range reads return zero
//  rd_x/rd_y    : registered position of ship rd_idx
//  rd_heading   : registered heading of ship rd_idx
//  busy         : high while ships are being updated
//  upd_done     : one-cycle pulse after the last ship of a pass
//  overrun      : sticky, set by a frame_tick during a pass; cleared only by rst
module spacewar_ship_kinematics
  import spacewar_pkg::*;
#(
  parameter int NUM_SHIPS = 2,
  parameter int POS_W     = 10,
  parameter int VEL_W     = 6,
  parameter int FIELD_W   = 640,
  parameter int FIELD_H   = 480,
  localparam int IDX_W    = $clog2(NUM_SHIPS) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_tick,
  input  logic [3*NUM_SHIPS-1:0] ctrl_in,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [POS_W-1:0]       rd_x,
  output logic [POS_W-1:0]       rd_y,
  output heading_t               rd_heading,
  output logic                   busy,
  output logic                   upd_done,
  output logic                   overrun
);

  localparam int VMAX = 2 ** (VEL_W - 1) - 1;

  typedef enum logic [1:0] {StIdle, StUpd, StDone} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       k_q, k_d;
  logic [3*NUM_SHIPS-1:0] snap_q;
  logic                   overrun_q;

  logic [POS_W-1:0]        x_q  [NUM_SHIPS];
  logic [POS_W-1:0]        y_q  [NUM_SHIPS];
  logic signed [VEL_W-1:0] vx_q [NUM_SHIPS];
  logic signed [VEL_W-1:0] vy_q [NUM_SHIPS];
  heading_t                h_q  [NUM_SHIPS];

  logic [2:0]              cur_ctrl;
  logic [POS_W-1:0]        cur_x, cur_y, new_x, new_y;
  logic signed [VEL_W-1:0] cur_vx, cur_vy, new_vx, new_vy;
  heading_t                cur_h, new_h;
  accel_t                  acc;

  // Select the ship addressed by the pass counter.
  always_comb begin
    cur_ctrl = '0;
    cur_x    = '0;
    cur_y    = '0;
    cur_vx   = '0;
    cur_vy   = '0;
    cur_h    = '0;
    for (int i = 0; i < NUM_SHIPS; i++) begin
      if (k_q == IDX_W'(i)) begin
        cur_ctrl = snap_q[3*i +: 3];
        cur_x    = x_q[i];
        cur_y    = y_q[i];
        cur_vx   = vx_q[i];
        cur_vy   = vy_q[i];
        cur_h    = h_q[i];
      end
    end
  end

  // Heading first; thrust then uses the new heading.
  always_comb begin
    new_h = cur_h;
    if (cur_ctrl[ROT_L] && !cur_ctrl[ROT_R]) begin
      new_h = cur_h + 3'd1;
    end else if (cur_ctrl[ROT_R] && !cur_ctrl[ROT_L]) begin
      new_h = cur_h - 3'd1;
    end
    acc    = accel(new_h);
    new_vx = cur_vx;
    new_vy = cur_vy;
    if (cur_ctrl[THRUST]) begin
      new_vx = VEL_W'(sat_add(int'(cur_vx), int'(acc.dx), VMAX));
      new_vy = VEL_W'(sat_add(int'(cur_vy), int'(acc.dy), VMAX));
    end
  end

  spacewar_wrap_add #(
    .POS_W(POS_W),
    .VEL_W(VEL_W),
    .FIELD(FIELD_W)
  ) u_wrap_x (
    .pos(cur_x),
    .vel(new_vx),
    .sum(new_x)
  );

  spacewar_wrap_add #(
    .POS_W(POS_W),
    .VEL_W(VEL_W),
    .FIELD(FIELD_H)
  ) u_wrap_y (
    .pos(cur_y),
    .vel(new_vy),
    .sum(new_y)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (frame_tick) begin
          state_d = StUpd;
          k_d     = '0;
        end
      end
      StUpd: begin
        if (k_q == IDX_W'(NUM_SHIPS - 1)) begin
          state_d = StDone;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      k_q       <= '0;
      snap_q    <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_SHIPS; i++) begin
        x_q[i]  <= POS_W'((i + 1) * FIELD_W / (NUM_SHIPS + 1));
        y_q[i]  <= POS_W'(FIELD_H / 2);
        vx_q[i] <= '0;
        vy_q[i] <= '0;
        h_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (state_q == StIdle && frame_tick) begin
        snap_q <= ctrl_in;
      end
      if (state_q != StIdle && frame_tick) begin
        overrun_q <= 1'b1;
      end
      if (state_q == StUpd) begin
        for (int i = 0; i < NUM_SHIPS; i++) begin
          if (k_q == IDX_W'(i)) begin
            x_q[i]  <= new_x;
            y_q[i]  <= new_y;
            vx_q[i] <= new_vx;
            vy_q[i] <= new_vy;
            h_q[i]  <= new_h;
          end
        end
      end
    end
  end

  assign busy     = (state_q == StUpd);
  assign upd_done = (state_q == StDone);
  assign overrun  = overrun_q;

  always_comb begin
    rd_x       = '0;
    rd_y       = '0;
    rd_heading = '0;
    for (int i = 0; i < NUM_SHIPS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_x       = x_q[i];
        rd_y       = y_q[i];
        rd_heading = h_q[i];
      end
    end
  end

endmodule

// File: tb/tb_spacewar_ship_kinematics.sv
// Self-checking bench for spacewar_ship_kinematics (2 ships, 640x480, VEL_W=6).
module tb_spacewar_ship_kinematics;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic [5:0] ctrl_in = '0;
  logic [1:0] rd_idx = '0;
  logic [9:0] rd_x, rd_y;
  logic [2:0] rd_heading;
  logic       busy, upd_done, overrun;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int mx[2], my[2], mvx[2], mvy[2], mh[2];
  int ax_tab[8] = '{1, 1, 0, -1, -1, -1, 0, 1};
  int ay_tab[8] = '{0, -1, -1, -1, 0, 1, 1, 1};

  typedef struct {
    logic [5:0] ctrl;
    int x0, y0, h0, x1, y1, h1;
  } vec_t;
  vec_t vecs[6];

  spacewar_ship_kinematics #(
    .NUM_SHIPS(2),
    .POS_W(10),
    .VEL_W(6),
    .FIELD_W(640),
    .FIELD_H(480)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_tick(frame_tick),
    .ctrl_in(ctrl_in),
    .rd_idx(rd_idx),
    .rd_x(rd_x),
    .rd_y(rd_y),
    .rd_heading(rd_heading),
    .busy(busy),
    .upd_done(upd_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int clamp31(input int v);
    return (v > 31) ? 31 : ((v < -31) ? -31 : v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = (i + 1) * 640 / 3;
      my[i] = 240;
      mvx[i] = 0;
      mvy[i] = 0;
      mh[i] = 0;
    end
  endtask

  task automatic model_frame(input logic [5:0] c);
    logic [2:0] b;
    for (int i = 0; i < 2; i++) begin
      b = c[3*i +: 3];
      if (b[0] && !b[1]) mh[i] = (mh[i] + 1) % 8;
      else if (b[1] && !b[0]) mh[i] = (mh[i] + 7) % 8;
      if (b[2]) begin
        mvx[i] = clamp31(mvx[i] + ax_tab[mh[i]]);
        mvy[i] = clamp31(mvy[i] + ay_tab[mh[i]]);
      end
      mx[i] = ((mx[i] + mvx[i]) % 640 + 640) % 640;
      my[i] = ((my[i] + mvy[i]) % 480 + 480) % 480;
    end
  endtask

  task automatic read_ship(input int i, output int x, output int y, output int h);
    rd_idx = 2'(i);
    #1;
    x = int'(rd_x);
    y = int'(rd_y);
    h = int'(rd_heading);
  endtask

  task automatic check_ships(input string tag);
    int x, y, h;
    for (int i = 0; i < 2; i++) begin
      read_ship(i, x, y, h);
      check($sformatf("%s_x%0d", tag, i), x, mx[i]);
      check($sformatf("%s_y%0d", tag, i), y, my[i]);
      check($sformatf("%s_h%0d", tag, i), h, mh[i]);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One full pass; ctrl_in is scrambled after the tick to exercise the snapshot.
  task automatic run_frame(input logic [5:0] c);
    int n;
    @(posedge clk); #1;
    ctrl_in = c;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    ctrl_in = 6'($urandom);
    n = 0;
    while (!upd_done && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("frame_done", int'(upd_done), 1);
    model_frame(c);
  endtask

  initial begin
    int x, y, h, xa, ya, xb, yb, seen;

    vecs[0] = '{6'b000_100, 214, 240, 0, 426, 240, 0};
    vecs[1] = '{6'b000_100, 216, 240, 0, 426, 240, 0};
    vecs[2] = '{6'b000_100, 219, 240, 0, 426, 240, 0};
    vecs[3] = '{6'b010_001, 222, 240, 1, 426, 240, 7};
    vecs[4] = '{6'b101_011, 225, 240, 1, 427, 240, 0};
    vecs[5] = '{6'b101_101, 228, 239, 2, 429, 239, 1};

    // Reset state
    do_reset();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(upd_done), 0);
    check("rst_overrun", int'(overrun), 0);
    read_ship(0, x, y, h);
    check("rst_x0", x, 213);
    check("rst_y0", y, 240);
    check("rst_h0", h, 0);
    read_ship(1, x, y, h);
    check("rst_x1", x, 426);
    check("rst_y1", y, 240);

    // Pass timing: busy in T+1..T+2, done in T+3
    @(posedge clk); #1;
    ctrl_in = '0;
    frame_tick = 1'b1;
    check("t_busy_T", int'(busy), 0);
    @(posedge clk); #1;
    frame_tick = 1'b0;
    check("t_busy_T1", int'(busy), 1);
    check("t_done_T1", int'(upd_done), 0);
    @(posedge clk); #1;
    check("t_busy_T2", int'(busy), 1);
    check("t_done_T2", int'(upd_done), 0);
    @(posedge clk); #1;
    check("t_busy_T3", int'(busy), 0);
    check("t_done_T3", int'(upd_done), 1);
    @(posedge clk); #1;
    check("t_done_T4", int'(upd_done), 0);
    check("t_overrun", int'(overrun), 0);
    model_frame(6'b000_000);

    // Directed vectors: thrust, rotation, thrust on rotate
    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].ctrl);
      read_ship(0, x, y, h);
      check($sformatf("vec%0d_x0", v), x, vecs[v].x0);
      check($sformatf("vec%0d_y0", v), y, vecs[v].y0);
      check($sformatf("vec%0d_h0", v), h, vecs[v].h0);
      read_ship(1, x, y, h);
      check($sformatf("vec%0d_x1", v), x, vecs[v].x1);
      check($sformatf("vec%0d_y1", v), y, vecs[v].y1);
      check($sformatf("vec%0d_h1", v), h, vecs[v].h1);
    end
    check_ships("vec_model");

    // Overrun: second tick in T+1 and ctrl change must not disturb the pass
    @(posedge clk); #1;
    ctrl_in = 6'b100_100;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    check("ovr_busy_T1", int'(busy), 1);
    ctrl_in = 6'b011_011;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    check("ovr_busy_T2", int'(busy), 1);
    check("ovr_flag", int'(overrun), 1);
    @(posedge clk); #1;
    check("ovr_done_T3", int'(upd_done), 1);
    check("ovr_busy_T3", int'(busy), 0);
    @(posedge clk); #1;
    check("ovr_done_T4", int'(upd_done), 0);
    check("ovr_busy_T4", int'(busy), 0);
    check("ovr_sticky", int'(overrun), 1);
    model_frame(6'b100_100);
    check_ships("ovr");

    // rst in T+1: everything back to reset, no done pulse
    @(posedge clk); #1;
    ctrl_in = 6'b100_100;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rmid_busy", int'(busy), 0);
    check("rmid_overrun", int'(overrun), 0);
    seen = int'(upd_done);
    repeat (5) begin
      @(posedge clk); #1;
      if (upd_done) seen = 1;
    end
    check("rmid_no_done", seen, 0);
    model_reset();
    check_ships("rmid");

    // Saturation and wrap: ship0 thrusts along +x, ship1 turns to h=6 and thrusts down
    for (int f = 0; f < 40; f++) begin
      run_frame({(f < 2) ? 3'b010 : 3'b100, 3'b100});
      check_ships("sat_up");
    end
    read_ship(0, xa, y, h);
    read_ship(1, x, ya, h);
    run_frame(6'b100_100);
    read_ship(0, xb, y, h);
    read_ship(1, x, yb, h);
    check("sat_vx_pos", (xb - xa + 640) % 640, 31);
    check("sat_vy_pos", (yb - ya + 480) % 480, 31);
    for (int f = 0; f < 4; f++) begin
      run_frame(6'b000_001);
      check_ships("sat_rot");
    end
    for (int f = 0; f < 62; f++) begin
      run_frame(6'b000_100);
      check_ships("sat_dn");
    end
    read_ship(0, xa, y, h);
    run_frame(6'b000_100);
    read_ship(0, xb, y, h);
    check("sat_vx_neg", (xb - xa + 640) % 640, 609);
    check_ships("sat_end");

    // Randomized frames against the model
    for (int r = 0; r < 60; r++) begin
      run_frame(6'($urandom));
      check_ships("rand");
    end

    // Out-of-range read index returns zeros
    for (int i = 2; i < 4; i++) begin
      read_ship(i, x, y, h);
      check($sformatf("oor_x%0d", i), x, 0);
      check($sformatf("oor_y%0d", i), y, 0);
      check($sformatf("oor_h%0d", i), h, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
